game_round_ctrl: RTL and testbench

Top-level round sequencer for the symbol-counting game. It drives the symbol generator for a fixed generation window, then triggers the answer period and waits for its completion pulse. It then compares the player's count with the true count, shows the result, and advances through a fixed number of rounds. It sits between the button inputs, the symbol generator, the answer-period block and the seven-segment display mux.

---
 rtl/game_pkg.sv | 21 ++
 rtl/game_sec_timer.sv | 29 ++
 rtl/game_round_ctrl.sv | 141 ++++++++++++++
 tb/tb_game_round_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the symbol-counting game.
// Provides the round-sequencer state enum, data widths and default second counts.
package game_pkg;

  localparam int CNT_W   = 8;
  localparam int ROUND_W = 4;

  localparam int DEF_GEN_S    = 10;
  localparam int DEF_ANSWER_S = 8;
  localparam int DEF_SCORE_S  = 3;
  localparam int DEF_ROUNDS   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_ANSWER,
    S_SCORE,
    S_DONE
  } state_t;

endpackage

// File: rtl/game_sec_timer.sv
// Seconds down-counter shared by all timed states of the round sequencer.
// Ports: clk, rst_n, i_load/i_load_val (reload), i_tick (1 Hz pulse), o_expired (pulse).
module sec_timer
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // A tick coinciding with a load is swallowed by the load.
  assign o_expired = i_tick & ~i_load & (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: generation window, answer period, scoring, round count.
// Ports: Clk100M/rst_n, secTick, startBtn, genCount, userCount, postSig in;
//        genRun, answerSig, roundNum, score, resultValid, resultCorrect,
//        timeoutErr, gameOver out (all registered).
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int GEN_SECONDS    = DEF_GEN_S,
  parameter int ANSWER_TIMEOUT = DEF_ANSWER_S,
  parameter int SCORE_SECONDS  = DEF_SCORE_S,
  parameter int NUM_ROUNDS     = DEF_ROUNDS
) (
  input  logic               Clk100M,
  input  logic               rst_n,
  input  logic               secTick,
  input  logic               startBtn,
  input  logic [CNT_W-1:0]   genCount,
  input  logic [CNT_W-1:0]   userCount,
  input  logic               postSig,
  output logic               genRun,
  output logic               answerSig,
  output logic [ROUND_W-1:0] roundNum,
  output logic [CNT_W-1:0]   score,
  output logic               resultValid,
  output logic               resultCorrect,
  output logic               timeoutErr,
  output logic               gameOver
);

  state_t           r_state;
  logic             r_load;
  logic             r_start_q;
  logic [CNT_W-1:0] r_true_cnt;
  logic [CNT_W-1:0] w_load_val;
  logic             w_expired;
  logic             w_start;
  logic             w_match;
  logic             w_last;

  assign w_start = startBtn & ~r_start_q;
  assign w_match = (userCount == r_true_cnt);
  assign w_last  = (roundNum == ROUND_W'(NUM_ROUNDS - 1));

  // r_load is high in the first cycle of a state, so r_state already
  // selects the new state's duration.
  always_comb begin
    w_load_val = '0;
    unique case (r_state)
      S_GEN:    w_load_val = CNT_W'(GEN_SECONDS);
      S_ANSWER: w_load_val = CNT_W'(ANSWER_TIMEOUT);
      S_SCORE:  w_load_val = CNT_W'(SCORE_SECONDS);
      default:  w_load_val = '0;
    endcase
  end

  sec_timer u_timer (
    .clk        (Clk100M),
    .rst_n      (rst_n),
    .i_load     (r_load),
    .i_load_val (w_load_val),
    .i_tick     (secTick),
    .o_expired  (w_expired)
  );

  always_ff @(posedge Clk100M or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_load        <= 1'b0;
      r_start_q     <= 1'b0;
      r_true_cnt    <= '0;
      genRun        <= 1'b0;
      answerSig     <= 1'b0;
      roundNum      <= '0;
      score         <= '0;
      resultValid   <= 1'b0;
      resultCorrect <= 1'b0;
      timeoutErr    <= 1'b0;
      gameOver      <= 1'b0;
    end else begin
      r_start_q  <= startBtn;
      r_load     <= 1'b0;
      answerSig  <= 1'b0;
      timeoutErr <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state  <= S_GEN;
            r_load   <= 1'b1;
            genRun   <= 1'b1;
            gameOver <= 1'b0;
            roundNum <= '0;
            score    <= '0;
          end
        end
        S_GEN: begin
          if (w_expired) begin
            r_state    <= S_ANSWER;
            r_load     <= 1'b1;
            r_true_cnt <= genCount;
            genRun     <= 1'b0;
            answerSig  <= 1'b1;
          end
        end
        S_ANSWER: begin
          // A post in the expiring cycle still gets judged.
          if (postSig) begin
            r_state       <= S_SCORE;
            r_load        <= 1'b1;
            resultValid   <= 1'b1;
            resultCorrect <= w_match;
            if (w_match && (score != '1)) begin
              score <= score + CNT_W'(1);
            end
          end else if (w_expired) begin
            r_state       <= S_SCORE;
            r_load        <= 1'b1;
            resultValid   <= 1'b1;
            resultCorrect <= 1'b0;
            timeoutErr    <= 1'b1;
          end
        end
        S_SCORE: begin
          if (w_expired) begin
            resultValid <= 1'b0;
            if (w_last) begin
              r_state  <= S_DONE;
              gameOver <= 1'b1;
            end else begin
              r_state  <= S_GEN;
              r_load   <= 1'b1;
              genRun   <= 1'b1;
              roundNum <= roundNum + ROUND_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl.
// Table-driven rounds, randomized games, and hand-written reset/restart sequences.
module tb_game_round_ctrl;

  localparam int GEN_S = 10;
  localparam int ANS_S = 8;
  localparam int SCR_S = 3;
  localparam int NR    = 3;

  logic       Clk100M = 1'b0;
  logic       rst_n = 1'b0;
  logic       secTick = 1'b0;
  logic       startBtn = 1'b0;
  logic       postSig = 1'b0;
  logic [7:0] genCount = 8'd0;
  logic [7:0] userCount = 8'd0;

  logic       genRun;
  logic       answerSig;
  logic [3:0] roundNum;
  logic [7:0] score;
  logic       resultValid;
  logic       resultCorrect;
  logic       timeoutErr;
  logic       gameOver;

  int total = 0;
  int bad = 0;
  int ans_cnt = 0;
  int to_cnt = 0;
  int score_m = 0;
  int round_m = 0;

  typedef struct {
    logic [7:0] g;
    logic [7:0] u;
    int         mode;
    logic       ok;
  } vec_t;

  vec_t vecs[6];

  game_round_ctrl #(
    .GEN_SECONDS    (GEN_S),
    .ANSWER_TIMEOUT (ANS_S),
    .SCORE_SECONDS  (SCR_S),
    .NUM_ROUNDS     (NR)
  ) dut (
    .Clk100M       (Clk100M),
    .rst_n         (rst_n),
    .secTick       (secTick),
    .startBtn      (startBtn),
    .genCount      (genCount),
    .userCount     (userCount),
    .postSig       (postSig),
    .genRun        (genRun),
    .answerSig     (answerSig),
    .roundNum      (roundNum),
    .score         (score),
    .resultValid   (resultValid),
    .resultCorrect (resultCorrect),
    .timeoutErr    (timeoutErr),
    .gameOver      (gameOver)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int outs();
    return {14'd0, genRun, answerSig, resultValid, resultCorrect,
            timeoutErr, gameOver, roundNum, score};
  endfunction

  task automatic clk1(input logic t, input logic p);
    secTick = t;
    postSig = p;
    @(posedge Clk100M);
    #1;
    secTick = 1'b0;
    postSig = 1'b0;
    if (answerSig) ans_cnt++;
    if (timeoutErr) to_cnt++;
  endtask

  function automatic logic phase_on(input int sel);
    case (sel)
      0:       return genRun;
      1:       return resultValid;
      default: return !(genRun || resultValid || gameOver);
    endcase
  endfunction

  // Entry cycle carries a tick that must be ignored; then count ticks
  // until the phase ends. poke adds a start edge and a stray postSig.
  task automatic timed_phase(input int sel, input int gap,
                             input logic poke, output int n);
    int   lim;
    logic t;
    n = 0;
    lim = 0;
    clk1(1'b1, 1'b0);
    while (phase_on(sel) && lim < 1000) begin
      t = ((lim % gap) == gap - 1);
      if (t) n++;
      if (poke && lim == 1) startBtn = 1'b1;
      if (poke && lim == 3) startBtn = 1'b0;
      clk1(t, poke && (lim == 2));
      lim++;
    end
    startBtn = 1'b0;
    if (lim >= 1000) chk("phase_budget", lim, 0);
  endtask

  task automatic start_game();
    startBtn = 1'b0;
    clk1(1'b0, 1'b0);
    startBtn = 1'b1;
    clk1(1'b0, 1'b0);
    startBtn = 1'b0;
    score_m = 0;
    round_m = 0;
    chk("start_genRun", genRun, 1);
    chk("start_round", roundNum, 0);
    chk("start_score", score, 0);
    chk("start_gameOver", gameOver, 0);
  endtask

  // mode 0: early post, 1: no post (watchdog), 2: post on expiring tick
  task automatic do_round(input logic [7:0] g, input logic [7:0] u,
                          input int mode, input logic ok, input int gap);
    int n;
    int k;
    int a0;
    int t0;
    a0 = ans_cnt;
    t0 = to_cnt;
    genCount = g;
    timed_phase(0, gap, 1'b1, n);
    chk("gen_ticks", n, GEN_S);
    chk("ans_pulse_first", answerSig, 1);
    genCount = ~g;
    if (mode == 1) begin
      timed_phase(2, gap, 1'b0, n);
      chk("wd_ticks", n, ANS_S);
    end else begin
      k = (mode == 2) ? ANS_S - 1 : int'($urandom_range(0, ANS_S - 2));
      clk1(1'b1, 1'b0);
      repeat (k) begin
        repeat (gap - 1) clk1(1'b0, 1'b0);
        clk1(1'b1, 1'b0);
      end
      userCount = u;
      clk1(mode == 2, 1'b1);
      userCount = ~u;
    end
    if (ok && score_m < 255) score_m++;
    chk("score_valid", resultValid, 1);
    chk("verdict", resultCorrect, ok);
    chk("score", score, score_m);
    chk("timeoutErr", timeoutErr, (mode == 1) ? 1 : 0);
    timed_phase(1, gap, 1'b1, n);
    chk("score_ticks", n, SCR_S);
    chk("score_hold", score, score_m);
    chk("ans_pulses", ans_cnt - a0, 1);
    chk("to_pulses", to_cnt - t0, (mode == 1) ? 1 : 0);
    if (round_m == NR - 1) begin
      chk("done_gameOver", gameOver, 1);
      chk("done_genRun", genRun, 0);
      chk("done_round", roundNum, round_m);
    end else begin
      round_m++;
      chk("next_genRun", genRun, 1);
      chk("next_round", roundNum, round_m);
    end
  endtask

  initial begin
    int n;
    logic [7:0] gv;
    logic [7:0] uv;
    int md;

    vecs[0] = '{8'd23, 8'd23, 0, 1'b1};
    vecs[1] = '{8'd17, 8'd16, 0, 1'b0};
    vecs[2] = '{8'd40, 8'd40, 0, 1'b1};
    vecs[3] = '{8'd9,  8'd9,  1, 1'b0};
    vecs[4] = '{8'd5,  8'd5,  2, 1'b1};
    vecs[5] = '{8'd0,  8'd255, 2, 1'b0};

    repeat (3) @(posedge Clk100M);
    #1;
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    repeat (3) clk1(1'b1, 1'b1);
    chk("idle_outs", outs(), 0);

    for (int gm = 0; gm < 2; gm++) begin
      start_game();
      for (int r = 0; r < NR; r++) begin
        do_round(vecs[gm*NR + r].g, vecs[gm*NR + r].u,
                 vecs[gm*NR + r].mode, vecs[gm*NR + r].ok, 3);
      end
      if (gm == 0) chk("game1_score", score, 2);
      else chk("game2_score", score, 1);
      repeat (5) clk1(1'b1, 1'b1);
      chk("done_hold", gameOver, 1);
    end

    for (int gm = 0; gm < 4; gm++) begin
      start_game();
      for (int r = 0; r < NR; r++) begin
        gv = 8'($urandom);
        uv = ($urandom_range(0, 1) == 1) ? gv : 8'($urandom);
        md = int'($urandom_range(0, 2));
        do_round(gv, uv, md, (md != 1) && (uv == gv),
                 int'($urandom_range(2, 4)));
      end
    end

    start_game();
    genCount = 8'd3;
    timed_phase(0, 2, 1'b0, n);
    chk("rst_seq_gen", n, GEN_S);
    clk1(1'b0, 1'b0);
    clk1(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", outs(), 0);
    @(posedge Clk100M);
    @(posedge Clk100M);
    #1;
    rst_n = 1'b1;
    repeat (20) clk1(1'b1, 1'b1);
    chk("post_reset_idle", outs(), 0);
    start_game();
    genCount = 8'd77;
    do_round(8'd77, 8'd77, 0, 1'b1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

endmodule
